// File: rtl/buffer_drain.sv
// buffer_drain: pops PAR_READ-word chunks from the circular buffer and serializes them,
// lane 0 first, onto a one-word valid/ready stream. Define DRAIN_B2B_EN for bubble-free chunk reload.
module buffer_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_READ   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           empty,
  output logic                           enr,
  input  logic [DATA_WIDTH*PAR_READ-1:0] data_in,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  input  logic                           out_ready
);
  localparam int IDX_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_READ - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                         state_reg, state_next;
  logic [IDX_W-1:0]               idx_reg, idx_next;
  logic [DATA_WIDTH*PAR_READ-1:0] chunk_reg, chunk_next;
  logic [DATA_WIDTH-1:0]          lanes [PAR_READ];
  logic                           last_lane;

  genvar gi;
  generate
    for (gi = 0; gi < PAR_READ; gi++) begin : g_lanes
      assign lanes[gi] = chunk_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign last_lane = (idx_reg == LAST_IDX);

  // Lane select written as a compare chain so non-power-of-two PAR_READ never indexes past the array.
  always_comb begin
    out_data = lanes[0];
    for (int i = 1; i < PAR_READ; i++) begin
      if (idx_reg == IDX_W'(i)) out_data = lanes[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    chunk_next = chunk_reg;
    enr        = 1'b0;
    out_valid  = (state_reg == SEND);
    case (state_reg)
      IDLE: begin
        enr = !empty && !rst;
        if (enr) begin
          chunk_next = data_in;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!last_lane) begin
            idx_next = idx_reg + 1'b1;
          end else begin
`ifdef DRAIN_B2B_EN
            enr = !empty && !rst;
`endif
            if (enr) begin
              chunk_next = data_in;
              idx_next   = '0;
            end else begin
              state_next = IDLE;
              idx_next   = '0;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset drops any untransmitted lanes; the buffer pointer has already moved past them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      chunk_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      chunk_reg <= chunk_next;
    end
  end
endmodule

// File: tb/tb_buffer_drain.sv
// tb_buffer_drain: directed scenarios plus randomized traffic checked against a queue model
// of the buffer contents and of the word stream the drain owes downstream.
module tb_buffer_drain;
  localparam int W = 16;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         empty = 1'b1;
  logic         enr;
  logic [W*P-1:0] data_in = '0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;

  buffer_drain #(.DATA_WIDTH(W), .PAR_READ(P)) dut (
    .clk(clk), .rst(rst), .empty(empty), .enr(enr), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] buf_q[$];
  logic [W-1:0] exp_q[$];
  logic s_enr, s_valid, s_rst, p_hold;
  logic [W-1:0] s_data, p_data;
  bit saw_0bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void refresh();
    empty = (buf_q.size() < P);
    data_in = empty ? $urandom : {buf_q[1], buf_q[0]};
  endfunction

  function automatic void push_chunk(logic [31:0] c);
    buf_q.push_back(c[15:0]);
    buf_q.push_back(c[31:16]);
    refresh();
  endfunction

  // One clock: sample on the falling edge, then advance the model after the rising edge.
  task automatic cycle();
    @(negedge clk);
    s_enr = enr; s_valid = out_valid; s_rst = rst; s_data = out_data;
    check("enr_while_empty", enr & empty, 0);
    if (rst) check("enr_in_reset", enr, 0);
    if (p_hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, p_data);
    end
`ifdef DRAIN_B2B_EN
    if (enr && out_valid) check("b2b_enr_needs_beat", out_ready, 1);
`else
    check("enr_in_send", enr & out_valid, 0);
`endif
    if (out_valid && out_ready && !rst) begin
      if (out_data == 16'h0BAD) saw_0bad = 1;
      if (exp_q.size() == 0) check("unexpected_word", 1, 0);
      else check("word", out_data, exp_q.pop_front());
    end
    p_hold = (out_valid === 1'b1) && (out_ready === 1'b0) && !rst;
    p_data = out_data;
    @(posedge clk);
    #1;
    if (s_rst) exp_q.delete();
    else if (s_enr && buf_q.size() >= P) repeat (P) exp_q.push_back(buf_q.pop_front());
    refresh();
  endtask

  task automatic drain();
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((exp_q.size() > 0 || buf_q.size() >= P || s_valid) && n < 100);
    check("drain_done", n < 100, 1);
  endtask

  initial begin
    int enr_cnt, nvalid, first_v, last_v;
    p_hold = 1'b0;

    // Reset held with data available
    rst = 1; out_ready = 1; push_chunk(32'hBEEF_1234);
    cycle();
    repeat (2) begin
      cycle();
      check("rst_enr", s_enr, 0);
      check("rst_valid", s_valid, 0);
      check("rst_data", s_data, 0);
    end
    rst = 0;

    // Single chunk, first-word latency
    cycle(); check("first_enr", s_enr, 1); check("first_valid", s_valid, 0);
    enr_cnt = 1;
    cycle(); check("lane0_valid", s_valid, 1); check("lane0_data", s_data, 16'h1234); enr_cnt += int'(s_enr);
    cycle(); check("lane1_valid", s_valid, 1); check("lane1_data", s_data, 16'hBEEF); enr_cnt += int'(s_enr);
    cycle(); check("after_chunk_valid", s_valid, 0); enr_cnt += int'(s_enr);
    check("single_enr_count", enr_cnt, 1);

    // Backpressure
    out_ready = 0; push_chunk(32'hAAAA_5555);
    cycle(); check("bp_enr", s_enr, 1);
    repeat (5) begin
      cycle();
      check("bp_valid", s_valid, 1);
      check("bp_data", s_data, 16'h5555);
      check("bp_enr_low", s_enr, 0);
    end
    out_ready = 1; drain();

    // Streaming three chunks
    nvalid = 0; first_v = -1; last_v = -1;
    for (int i = 0; i < 3; i++) push_chunk($urandom);
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (s_valid) begin
        nvalid++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
    end
    check("stream_words", nvalid, 6);
`ifdef DRAIN_B2B_EN
    check("stream_span", last_v - first_v + 1, 6);
`else
    check("stream_span", last_v - first_v + 1, 8);
`endif
    drain();

    // Reset after lane 0 of a chunk
    saw_0bad = 0; push_chunk(32'h0BAD_F00D); push_chunk(32'h1234_5678); out_ready = 1;
    cycle(); check("mr_enr", s_enr, 1);
    cycle(); check("mr_lane0", s_data, 16'hF00D);
    rst = 1; out_ready = 0;
    cycle(); check("mr_rst_enr", s_enr, 0);
    rst = 0; out_ready = 1;
    cycle(); check("mr_valid_after_rst", s_valid, 0); check("mr_refetch_enr", s_enr, 1);
    cycle(); check("mr_next_valid", s_valid, 1); check("mr_next_lane0", s_data, 16'h5678);
    drain();
    check("mr_0bad_never", saw_0bad, 0);

    // Buffer runs empty on the last-lane beat
    push_chunk(32'h1111_2222); out_ready = 1;
    cycle(); check("el_enr", s_enr, 1);
    cycle(); check("el_lane0", s_data, 16'h2222);
    cycle(); check("el_lane1", s_data, 16'h1111); check("el_no_enr", s_enr, 0);
    cycle(); check("el_valid_low", s_valid, 0);

    // Randomized traffic, stalls and occasional resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        buf_q.push_back(16'($urandom));
        refresh();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0; out_ready = 1;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
